// File: rtl/seq_divider.sv
// Multicycle restoring integer divider: 32 steps, quotient on low, remainder on high.
// Optional DIV_UNSIGNED_EN macro enables unsigned (DIVU) operation via is_signed.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low,
  output logic             div_end,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ZERO} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [WIDTH-1:0] high_q, high_d, low_q, low_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             end_q, end_d, zero_q, zero_d;

  logic             sgn;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted;
  logic             ge;

`ifdef DIV_UNSIGNED_EN
  assign sgn = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sgn = 1'b1;
`endif

  // Magnitudes feed the unsigned core; signs are restored in DONE.
  assign a_abs   = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_abs   = (sgn && b[WIDTH-1]) ? -b : b;
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    high_d  = high_q;
    low_d   = low_q;
    end_d   = 1'b0;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: if (div) begin
        if (b == '0) begin
          state_d = ZERO;
        end else begin
          state_d = RUN;
          dvd_d   = a_abs;
          dvs_d   = b_abs;
          qneg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = sgn & a[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Remainder stays below the divisor, so WIDTH bits hold it after restore.
        rem_d = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      end
      DONE: begin
        low_d   = qneg_q ? -dvd_q : dvd_q;
        high_d  = rneg_q ? -rem_q : rem_q;
        end_d   = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        zero_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      high_q  <= '0;
      low_q   <= '0;
      end_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      high_q  <= high_d;
      low_q   <= low_d;
      end_q   <= end_d;
      zero_q  <= zero_d;
    end
  end

  assign high     = high_q;
  assign low      = low_q;
  assign div_end  = end_q;
  assign div_zero = zero_q;
  assign busy     = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signed results, zero divisor, overflow, abort, restart.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        div = 1'b0;
  logic        is_signed = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [31:0] high, low;
  logic        div_end, div_zero, busy;
  int          checks = 0, errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .div(div), .is_signed(is_signed), .a(a), .b(b),
    .high(high), .low(low), .div_end(div_end), .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Start edge is the posedge inside; returns #1 after it.
  task automatic start_div(input logic [31:0] av, input logic [31:0] bv, input logic s);
    @(negedge clk);
    a = av; b = bv; is_signed = s; div = 1'b1;
    @(posedge clk); #1;
    div = 1'b0;
  endtask

  // Edges after the start edge until div_end is seen (40 = timeout).
  task automatic wait_end(output int n);
    n = 0;
    while (!div_end && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (high !== 32'h0) begin errors++; $display("FAIL reset_high got %h want 0", high); end
    checks++; if (low !== 32'h0) begin errors++; $display("FAIL reset_low got %h want 0", low); end
    checks++; if (div_end !== 1'b0) begin errors++; $display("FAIL reset_end got %b want 0", div_end); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_signed;
    int n;
    start_div(32'd100, 32'd7, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL s1_busy got %b want 1", busy); end
    wait_end(n);
    checks++; if (n != 33) begin errors++; $display("FAIL s1_latency got %0d want 33", n); end
    checks++; if (low !== 32'd14) begin errors++; $display("FAIL s1_low got %h want %h", low, 32'd14); end
    checks++; if (high !== 32'd2) begin errors++; $display("FAIL s1_high got %h want %h", high, 32'd2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s1_busy_done got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (div_end !== 1'b0) begin errors++; $display("FAIL s1_end_drop got %b want 0", div_end); end

    start_div(32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_end(n);
    checks++; if (low !== 32'hFFFF_FFF2) begin errors++; $display("FAIL s2_low got %h want fffffff2", low); end
    checks++; if (high !== 32'hFFFF_FFFE) begin errors++; $display("FAIL s2_high got %h want fffffffe", high); end

    start_div(32'd100, 32'hFFFF_FFF9, 1'b1);
    wait_end(n);
    checks++; if (low !== 32'hFFFF_FFF2) begin errors++; $display("FAIL s3_low got %h want fffffff2", low); end
    checks++; if (high !== 32'd2) begin errors++; $display("FAIL s3_high got %h want 2", high); end
  endtask

  task automatic test_zero;
    int ends = 0;
    start_div(32'd5, 32'd0, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL z_busy got %b want 0", busy); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL z_early got %b want 0", div_zero); end
    @(posedge clk); #1;
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL z_pulse got %b want 1", div_zero); end
    checks++; if (div_end !== 1'b0) begin errors++; $display("FAIL z_noend got %b want 0", div_end); end
    checks++; if (low !== 32'hFFFF_FFF2) begin errors++; $display("FAIL z_low_hold got %h want fffffff2", low); end
    checks++; if (high !== 32'd2) begin errors++; $display("FAIL z_high_hold got %h want 2", high); end
    @(posedge clk); #1;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL z_drop got %b want 0", div_zero); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (div_end) ends++;
    end
    checks++; if (ends != 0) begin errors++; $display("FAIL z_stray_end got %0d want 0", ends); end
  endtask

  task automatic test_overflow_ignore;
    int ends = 0, first = -1;
    start_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      div = (n == 10);
      a = 32'd7; b = (n == 10) ? 32'd0 : 32'd3;
      @(posedge clk); #1;
      div = 1'b0;
      if (div_end) begin
        ends++;
        if (first < 0) first = n;
        checks++; if (low !== 32'h8000_0000) begin errors++; $display("FAIL ov_low got %h want 80000000", low); end
        checks++; if (high !== 32'h0) begin errors++; $display("FAIL ov_high got %h want 0", high); end
      end
      if (div_zero) begin
        checks++; errors++; $display("FAIL ov_zero got 1 want 0 at %0d", n);
      end
    end
    checks++; if (ends != 1) begin errors++; $display("FAIL ov_end_count got %0d want 1", ends); end
    checks++; if (first != 33) begin errors++; $display("FAIL ov_latency got %0d want 33", first); end
  endtask

  task automatic test_reset_abort;
    int n, ends = 0;
    start_div(32'd1000, 32'd3, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    #1 reset = 1'b0;
    #1;
    checks++; if (low !== 32'h0) begin errors++; $display("FAIL ab_low got %h want 0", low); end
    checks++; if (high !== 32'h0) begin errors++; $display("FAIL ab_high got %h want 0", high); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got %b want 0", busy); end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (div_end || div_zero) ends++;
    end
    checks++; if (ends != 0) begin errors++; $display("FAIL ab_stray_pulse got %0d want 0", ends); end
    start_div(32'd9, 32'd3, 1'b1);
    wait_end(n);
    checks++; if (n != 33) begin errors++; $display("FAIL ab_latency got %0d want 33", n); end
    checks++; if (low !== 32'd3) begin errors++; $display("FAIL ab_low2 got %h want 3", low); end
    checks++; if (high !== 32'd0) begin errors++; $display("FAIL ab_high2 got %h want 0", high); end
  endtask

  task automatic test_back_to_back;
    int n;
    start_div(32'd20, 32'd6, 1'b1);
    wait_end(n);
    checks++; if (low !== 32'd3 || high !== 32'd2) begin errors++; $display("FAIL bb1 got %h/%h want 3/2", low, high); end
    start_div(32'hFFFF_FFEC, 32'd6, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bb_accept got %b want 1", busy); end
    wait_end(n);
    checks++; if (n != 33) begin errors++; $display("FAIL bb_latency got %0d want 33", n); end
    checks++; if (low !== 32'hFFFF_FFFD) begin errors++; $display("FAIL bb2_low got %h want fffffffd", low); end
    checks++; if (high !== 32'hFFFF_FFFE) begin errors++; $display("FAIL bb2_high got %h want fffffffe", high); end
  endtask

  task automatic test_unsigned;
    int n;
    logic [31:0] exp_lo, exp_hi;
`ifdef DIV_UNSIGNED_EN
    exp_lo = 32'h7FFF_FFFF; exp_hi = 32'h1;
`else
    exp_lo = 32'h0; exp_hi = 32'hFFFF_FFFF;
`endif
    start_div(32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_end(n);
    checks++; if (n != 33) begin errors++; $display("FAIL u_latency got %0d want 33", n); end
    checks++; if (low !== exp_lo) begin errors++; $display("FAIL u_low got %h want %h", low, exp_lo); end
    checks++; if (high !== exp_hi) begin errors++; $display("FAIL u_high got %h want %h", high, exp_hi); end
  endtask

  initial begin
    test_reset;
    test_signed;
    test_zero;
    test_overflow_ignore;
    test_reset_abort;
    test_back_to_back;
    test_unsigned;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
